user_digest_extract: RTL and testbench
======================================

USER_DIGEST_EXTRACT -- requirements
Module: user_digest_extract

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256: packet data width.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 304: input tuser width (metadata plus digest).
REQ-003 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128: output tuser width.
REQ-004 SHALL have parameter DIGEST_WIDTH, default 256: digest field width, tuser[303:48].
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, a power of 2: digest FIFO entries.
REQ-006 SHALL have ports as follows; there is one clock, and reset is asynchronous and active-low:
- axis_aclk  in  1  clock
- axis_resetn  in  1  async active-low reset
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/304/1/1  packet from the SDNet user stage
- s_axis_tready  out  1
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  packet to the output queues
- m_axis_tready  in  1
- m_digest_tdata  out  256  digest to CPU path
- m_digest_tvalid  out  1
- m_digest_tready  in  1

Function
REQ-007 SHALL treat a beat as transferred when tvalid and tready are both high; tuser is sampled only on the first beat of a packet.
REQ-008 SHALL implement an FSM with states IDLE (awaiting first beat), PASS and DROP.
REQ-009 SHALL, on a first beat in IDLE with tlast=0, move to PASS if tuser[32]=0 and to DROP if tuser[32]=1.
REQ-010 SHALL return to IDLE from PASS or DROP on transfer of a beat with tlast=1; a single-beat packet (first beat tlast=1) stays in IDLE.
REQ-011 SHALL register the packet path with exactly one output register stage, giving 1 cycle latency from s transfer to m_axis_tvalid.
REQ-012 SHALL drive s_axis_tready = !m_axis_tvalid || m_axis_tready while not dropping.
REQ-013 SHALL hold s_axis_tready=1 for every beat of a dropped packet, including its first beat; dropped beats never reach m_axis.
REQ-014 SHALL form m_axis_tuser as {80'b0, first-beat tuser[47:0]} and hold it constant for every beat of the packet.
REQ-015 SHALL, when tuser[40]=1 on a transferred first beat, request a push of tuser[303:48] into the digest FIFO, whether or not the packet is dropped.
REQ-016 SHALL accept a push if the FIFO is not full, or if it is full and a pop happens in the same cycle.
REQ-017 SHALL discard a rejected digest silently, with no back-pressure on s_axis.
REQ-018 SHALL drive m_digest_tvalid = FIFO not empty and m_digest_tdata = FIFO head with no bubble; a push into an empty FIFO is visible on the next cycle.
REQ-019 SHALL, on a simultaneous push and pop with the FIFO empty, take only the push; the pop is not possible while tvalid=0.
REQ-020 SHALL let the read and write pointers wrap modulo FIFO_DEPTH, using an extra pointer bit to tell full from empty.
REQ-021 SHALL hold m_axis_* and m_digest_* stable while their tvalid=1 and tready=0.

Reset
REQ-022 SHALL, on axis_resetn low, asynchronously force: FSM to IDLE; m_axis_tvalid=0; m_axis_tdata/tkeep/tuser/tlast=0; FIFO pointers=0; m_digest_tvalid=0; m_digest_tdata=0.
REQ-023 SHALL drive s_axis_tready=0 while axis_resetn is low.
REQ-024 SHALL, after a reset that arrives mid-packet, treat the next transferred beat as a first beat; upstream is responsible for packet alignment.

Configuration
REQ-025 SHALL, with macro USER_DIGEST_OVERFLOW_CNT_EN defined, add output port digest_overflow_cnt (32 bits) that increments by 1 on each rejected push, saturates at 0xFFFFFFFF and resets to 0.
REQ-026 SHALL, with USER_DIGEST_OVERFLOW_CNT_EN undefined, have neither the port nor the counter, with all other behaviour identical.

Verification
REQ-027 Single 3-beat packet, tuser[47:0]=0x00_00_01_04_0040, tuser[40]=0, m_axis_tready=1 -> 3 beats out, each 1 cycle later, m_axis_tuser=0x...0001040040 with upper 80 bits zero, no digest.
REQ-028 2-beat packet with tuser[32]=1 and tuser[40]=1, digest=0xABCD -> no m_axis beats, s_axis_tready=1 both beats, m_digest_tdata=0xABCD valid 1 cycle after the first beat.
REQ-029 5 single-beat packets with tuser[40]=1 and m_digest_tready=0 -> 4 digests held in order; 5th lost; digest_overflow_cnt=1 when USER_DIGEST_OVERFLOW_CNT_EN is defined; all 5 packets forwarded.
REQ-030 FIFO full, m_digest_tready=1 in the same cycle as a 6th digest push -> push accepted, count remains 4, no overflow increment.
REQ-031 m_axis_tready toggled 1/0 every cycle over a 4-beat packet -> no beat lost or duplicated, data stable while stalled, tlast on the 4th beat only.
REQ-032 axis_resetn pulsed low for 1 cycle during beat 2 of a 4-beat packet -> all outputs zero immediately, FIFO empty, FSM IDLE; beat 3 is treated as a first beat.

Source files
------------

// File: rtl/user_digest_extract.sv
`default_nettype none
//==============================================================================
// Module   : user_digest_extract
// Purpose  : Registers the packet path, drops flagged packets and queues the
//            tuser digest for the CPU path. Option: USER_DIGEST_OVERFLOW_CNT_EN
// Revision : 1.0
//==============================================================================
module user_digest_extract #(
   parameter int C_AXIS_DATA_WIDTH    = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 304,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int DIGEST_WIDTH         = 256,
   parameter int FIFO_DEPTH           = 4
) (
   input  logic                              axis_aclk,
   input  logic                              axis_resetn,
   input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   output logic [DIGEST_WIDTH-1:0]           m_digest_tdata,
   output logic                              m_digest_tvalid,
`ifdef USER_DIGEST_OVERFLOW_CNT_EN
   output logic [31:0]                       digest_overflow_cnt,
`endif
   input  logic                              m_digest_tready
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PAD_W = C_M_AXIS_TUSER_WIDTH - 48;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [47:0]              r_meta;
   logic                     w_s_xfer;
   logic                     w_first;
   logic                     w_drop_beat;

   logic [DIGEST_WIDTH-1:0]  r_mem [FIFO_DEPTH];
   logic [AW:0]              r_wr_ptr;
   logic [AW:0]              r_rd_ptr;
   logic                     w_empty;
   logic                     w_full;
   logic                     w_pop;
   logic                     w_push_req;
   logic                     w_push;

   assign w_s_xfer    = s_axis_tvalid && s_axis_tready;
   assign w_first     = (r_state == ST_IDLE);
   // The first beat of a dropped packet is recognised from its own tuser.
   assign w_drop_beat = (r_state == ST_DROP) ||
                        (w_first && s_axis_tvalid && s_axis_tuser[32]);
   assign s_axis_tready = axis_resetn &&
                          (w_drop_beat || !m_axis_tvalid || m_axis_tready);

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) r_state <= ST_IDLE;
      else              r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_s_xfer) begin
         case (r_state)
            ST_IDLE: begin
               if (!s_axis_tlast)
                  w_state_nxt = s_axis_tuser[32] ? ST_DROP : ST_PASS;
            end
            ST_PASS, ST_DROP: begin
               if (s_axis_tlast) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
         r_meta        <= '0;
      end else begin
         if (w_s_xfer && w_first) r_meta <= s_axis_tuser[47:0];
         if (w_s_xfer && !w_drop_beat) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tuser  <= {{PAD_W{1'b0}}, (w_first ? s_axis_tuser[47:0] : r_meta)};
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

   // Digest FIFO: extra pointer bit separates full from empty.
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop      = m_digest_tvalid && m_digest_tready;
   assign w_push_req = w_s_xfer && w_first && s_axis_tuser[40];
   assign w_push     = w_push_req && (!w_full || w_pop);

   assign m_digest_tvalid = !w_empty;
   assign m_digest_tdata  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge axis_aclk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= s_axis_tuser[48 +: DIGEST_WIDTH];
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

`ifdef USER_DIGEST_OVERFLOW_CNT_EN
   logic w_reject;
   assign w_reject = w_push_req && !w_push;

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn)
         digest_overflow_cnt <= '0;
      else if (w_reject && (digest_overflow_cnt != 32'hFFFF_FFFF))
         digest_overflow_cnt <= digest_overflow_cnt + 32'd1;
   end
`else
   // Rejected digests are discarded without being counted.
`endif

endmodule
`default_nettype wire

// File: tb/tb_user_digest_extract.sv
`default_nettype none
//==============================================================================
// Module   : tb_user_digest_extract
// Purpose  : Self-checking bench for user_digest_extract against a queue model.
// Revision : 1.0
//==============================================================================
module tb_user_digest_extract;

   localparam int DW    = 256;
   localparam int KW    = DW / 8;
   localparam int SUW   = 304;
   localparam int MUW   = 128;
   localparam int DGW   = 256;
   localparam int DEPTH = 4;

   typedef struct {
      logic [DW-1:0]  data;
      logic [KW-1:0]  keep;
      logic [SUW-1:0] user;
      logic           last;
   } beat_t;

   logic              clk = 1'b0;
   logic              axis_resetn;
   logic [DW-1:0]     s_axis_tdata;
   logic [KW-1:0]     s_axis_tkeep;
   logic [SUW-1:0]    s_axis_tuser;
   logic              s_axis_tvalid;
   logic              s_axis_tlast;
   logic              s_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic [KW-1:0]     m_axis_tkeep;
   logic [MUW-1:0]    m_axis_tuser;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic              m_axis_tready;
   logic [DGW-1:0]    m_digest_tdata;
   logic              m_digest_tvalid;
   logic              m_digest_tready;
`ifdef USER_DIGEST_OVERFLOW_CNT_EN
   logic [31:0]       digest_overflow_cnt;
`endif

   always #5 clk = !clk;

   user_digest_extract dut (
      .axis_aclk       (clk),
      .axis_resetn     (axis_resetn),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tkeep    (s_axis_tkeep),
      .s_axis_tuser    (s_axis_tuser),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tlast    (s_axis_tlast),
      .s_axis_tready   (s_axis_tready),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tkeep    (m_axis_tkeep),
      .m_axis_tuser    (m_axis_tuser),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tready   (m_axis_tready),
      .m_digest_tdata  (m_digest_tdata),
      .m_digest_tvalid (m_digest_tvalid),
`ifdef USER_DIGEST_OVERFLOW_CNT_EN
      .digest_overflow_cnt (digest_overflow_cnt),
`endif
      .m_digest_tready (m_digest_tready)
   );

   int          n_total = 0;
   int          n_bad   = 0;

   // reference model state
   beat_t       stim_q[$];
   beat_t       exp_q[$];
   logic [DGW-1:0] dq[$];
   beat_t       cur;
   logic        have_pend = 1'b0;
   logic        in_pkt    = 1'b0;
   logic        pkt_drop  = 1'b0;
   logic [47:0] pkt_meta  = '0;
   logic        mv_model  = 1'b0;
   logic [31:0] ovf_model = '0;
   int          mr_mode = 0;   // 0 ready, 1 toggle, 2 random, 3 stalled
   int          dr_mode = 0;   // 0 stalled, 1 ready, 2 random
   logic        rand_valid = 1'b0;
   logic        tog = 1'b0;

   task automatic check_val(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_wide();
      logic [DW-1:0] v;
      for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic queue_pkt(input int len, input logic [SUW-1:0] first_user);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = rand_wide();
         b.keep = $urandom();
         b.user = (i == 0) ? first_user : {rand_wide(), 48'($urandom()) ^ 48'h5A5A_0000_0000};
         b.last = (i == len - 1);
         stim_q.push_back(b);
      end
   endtask

   task automatic step();
      logic  sx, mx, dpop, drop_ctx, exp_rdy;
      beat_t e;
      @(negedge clk);
      case (mr_mode)
         0:       m_axis_tready = 1'b1;
         1:       begin tog = !tog; m_axis_tready = tog; end
         2:       m_axis_tready = 1'($urandom_range(0, 1));
         default: m_axis_tready = 1'b0;
      endcase
      m_digest_tready = (dr_mode == 0) ? 1'b0 :
                        (dr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!have_pend && stim_q.size() > 0 && (!rand_valid || $urandom_range(0, 2) != 0)) begin
         cur = stim_q.pop_front();
         have_pend = 1'b1;
      end
      s_axis_tvalid = have_pend;
      s_axis_tdata  = have_pend ? cur.data : '0;
      s_axis_tkeep  = have_pend ? cur.keep : '0;
      s_axis_tuser  = have_pend ? cur.user : '0;
      s_axis_tlast  = have_pend ? cur.last : 1'b0;
      #1;
      drop_ctx = in_pkt ? pkt_drop : (have_pend && cur.user[32]);
      exp_rdy  = drop_ctx || !mv_model || m_axis_tready;
      check_val("s_tready", s_axis_tready, exp_rdy);
      check_val("m_tvalid", m_axis_tvalid, mv_model);
      if (mv_model && exp_q.size() > 0) begin
         check_val("m_tdata", m_axis_tdata, exp_q[0].data);
         check_val("m_tkeep", m_axis_tkeep, exp_q[0].keep);
         check_val("m_tuser", m_axis_tuser, exp_q[0].user[MUW-1:0]);
         check_val("m_tlast", m_axis_tlast, exp_q[0].last);
      end
      check_val("d_tvalid", m_digest_tvalid, dq.size() > 0);
      if (dq.size() > 0) check_val("d_tdata", m_digest_tdata, dq[0]);
`ifdef USER_DIGEST_OVERFLOW_CNT_EN
      check_val("ovf_cnt", digest_overflow_cnt, ovf_model);
`endif
      sx   = have_pend && s_axis_tready;
      mx   = mv_model && m_axis_tready;
      dpop = (dq.size() > 0) && m_digest_tready;
      if (mx && exp_q.size() > 0) void'(exp_q.pop_front());
      if (dpop) void'(dq.pop_front());
      if (mx) mv_model = 1'b0;
      if (sx) begin
         if (!in_pkt) begin
            pkt_meta = cur.user[47:0];
            pkt_drop = cur.user[32];
            if (cur.user[40]) begin
               if (dq.size() < DEPTH) dq.push_back(cur.user[SUW-1:48]);
               else if (ovf_model != 32'hFFFF_FFFF) ovf_model++;
            end
         end
         if (!pkt_drop) begin
            e.data = cur.data;
            e.keep = cur.keep;
            e.last = cur.last;
            e.user = '0;
            e.user[47:0] = pkt_meta;
            exp_q.push_back(e);
            mv_model = 1'b1;
         end
         in_pkt    = !cur.last;
         have_pend = 1'b0;
      end
   endtask

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      mr_mode = 0;
      dr_mode = 1;
      while ((stim_q.size() > 0 || have_pend || exp_q.size() > 0 || dq.size() > 0 || mv_model)
             && n < budget) begin
         step();
         n++;
      end
      if (n >= budget)
         check_val("drain_timeout", 320'(stim_q.size() + exp_q.size() + dq.size()), 320'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SUW-1:0] u;
      int len;
      axis_resetn     = 1'b0;
      s_axis_tvalid   = 1'b0;
      s_axis_tdata    = '0;
      s_axis_tkeep    = '0;
      s_axis_tuser    = '0;
      s_axis_tlast    = 1'b0;
      m_axis_tready   = 1'b0;
      m_digest_tready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_val("rst_s_tready", s_axis_tready, 1'b0);
      check_val("rst_m_tvalid", m_axis_tvalid, 1'b0);
      check_val("rst_m_tdata",  m_axis_tdata, '0);
      check_val("rst_m_tuser",  m_axis_tuser, '0);
      check_val("rst_d_tvalid", m_digest_tvalid, 1'b0);
      check_val("rst_d_tdata",  m_digest_tdata, '0);
      @(negedge clk);
      axis_resetn = 1'b1;

      // 3-beat pass-through packet, no digest
      mr_mode = 0; dr_mode = 0;
      u = '0; u[47:0] = 48'h0000_0104_0040;
      queue_pkt(3, u);
      repeat (6) step();
      check_val("t1_tuser", m_axis_tuser, 128'h0000_0104_0040);
      check_val("t1_nodigest", m_digest_tvalid, 1'b0);

      // 2-beat dropped packet with digest 0xABCD
      u = '0; u[32] = 1'b1; u[40] = 1'b1; u[SUW-1:48] = 256'hABCD;
      queue_pkt(2, u);
      repeat (4) step();
      check_val("t2_digest", m_digest_tdata, 256'hABCD);
      run_until_idle(50);

      // five single-beat digests into a stalled FIFO
      dr_mode = 0; mr_mode = 0;
      for (int i = 1; i <= 5; i++) begin
         u = '0; u[40] = 1'b1; u[47:44] = 4'(i); u[SUW-1:48] = 256'(i);
         queue_pkt(1, u);
      end
      repeat (10) step();
      check_val("t3_head", m_digest_tdata, 256'd1);
`ifdef USER_DIGEST_OVERFLOW_CNT_EN
      check_val("t3_ovf", digest_overflow_cnt, 32'd1);
`endif
      // sixth digest lands in the same cycle as a pop from a full FIFO
      u = '0; u[40] = 1'b1; u[SUW-1:48] = 256'd6;
      queue_pkt(1, u);
      dr_mode = 1;
      step();
      dr_mode = 0;
      repeat (3) step();
      check_val("t4_head", m_digest_tdata, 256'd2);
`ifdef USER_DIGEST_OVERFLOW_CNT_EN
      check_val("t4_ovf", digest_overflow_cnt, 32'd1);
`endif
      run_until_idle(50);

      // 4-beat packet with m_axis_tready toggling every cycle
      mr_mode = 1; tog = 1'b0;
      u = '0; u[47:0] = 48'hBEEF_0000_1111;
      queue_pkt(4, u);
      repeat (12) step();
      run_until_idle(50);

      // reset pulse during beat 2; beat 3 becomes a new first beat
      mr_mode = 0; dr_mode = 0;
      u = '0; u[40] = 1'b1; u[SUW-1:48] = 256'h77;
      queue_pkt(2, u);
      u = '0; u[47:0] = 48'h1234_5678_9ABC;
      queue_pkt(2, u);
      step();
      @(negedge clk);
      axis_resetn = 1'b0;
      cur = stim_q.pop_front();
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = cur.data;
      s_axis_tuser  = cur.user;
      s_axis_tlast  = cur.last;
      #1;
      check_val("prst_s_tready", s_axis_tready, 1'b0);
      check_val("prst_m_tvalid", m_axis_tvalid, 1'b0);
      check_val("prst_m_tdata",  m_axis_tdata, '0);
      check_val("prst_m_tuser",  m_axis_tuser, '0);
      check_val("prst_d_tvalid", m_digest_tvalid, 1'b0);
      check_val("prst_d_tdata",  m_digest_tdata, '0);
      exp_q.delete(); dq.delete();
      have_pend = 1'b0; in_pkt = 1'b0; mv_model = 1'b0; ovf_model = '0;
      @(negedge clk);
      axis_resetn   = 1'b1;
      s_axis_tvalid = 1'b0;
      step();
      step();
      check_val("prst_first_meta", m_axis_tuser, 128'h1234_5678_9ABC);
      run_until_idle(50);

      // randomized traffic
      for (int p = 0; p < 300; p++) begin
         len = $urandom_range(1, 5);
         u = {rand_wide(), 48'($urandom()) ^ (48'($urandom()) << 16)};
         u[32] = ($urandom_range(0, 3) == 0) && (len > 1);
         u[40] = 1'($urandom_range(0, 1));
         queue_pkt(len, u);
      end
      rand_valid = 1'b1;
      mr_mode = 2; dr_mode = 2;
      for (int n = 0; n < 20000 && (stim_q.size() > 0 || have_pend); n++) step();
      rand_valid = 1'b0;
      run_until_idle(200);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
